// File: rtl/led_channel_blinker_pkg.sv
// Shared definitions for the LED channel blinker: mode encodings, the reset
// heartbeat rate and a channel-select width helper.
package led_channel_blinker_pkg;

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_PWM   = 2'd3;

   // 50 ticks per half-period: 1 Hz blink on a 100 Hz tick
   localparam int unsigned RESET_RATE = 49;

   function automatic int unsigned chan_width(input int unsigned num_leds);
      return (num_leds > 1) ? $clog2(num_leds) : 1;
   endfunction

endpackage

// File: rtl/led_channel_blinker_tick_prescaler.sv
// Blink time base: divides clk by CLK_HZ/TICK_HZ and flags the last count of
// each period as a one-cycle tick.
module led_channel_blinker_tick_prescaler #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 100
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tick
);
   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_tick = (r_count == LAST);

endmodule

// File: rtl/led_channel_blinker.sv
// NUM_LEDS independent LED channels, each OFF, ON, BLINK or PWM, configured over a
// valid/ready write port. Channel 0 blinks at 1 Hz out of reset as the board heartbeat.
module led_channel_blinker
   import led_channel_blinker_pkg::*;
#(
   parameter int unsigned NUM_LEDS = 8,
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned TICK_HZ  = 100,
   parameter int unsigned RATE_W   = 8,
   parameter int unsigned PWM_W    = 8,
   localparam int unsigned CHAN_W  = chan_width(NUM_LEDS)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_cfg_valid,
   output logic                o_cfg_ready,
   input  logic [CHAN_W-1:0]   i_cfg_chan,
   input  logic [1:0]          i_cfg_mode,
   input  logic [RATE_W-1:0]   i_cfg_rate,
   input  logic [PWM_W-1:0]    i_cfg_duty,
   output logic [NUM_LEDS-1:0] o_led
);

   logic             w_tick;
   logic             w_wr;
   logic             r_cfg_ready;
   logic [PWM_W-1:0] r_pwm_cnt;

   led_channel_blinker_tick_prescaler #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_prescaler (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .o_tick (w_tick)
   );

   // Ready rises one cycle after reset release and then stays high
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cfg_ready <= 1'b0;
         r_pwm_cnt   <= '0;
      end else begin
         r_cfg_ready <= 1'b1;
         r_pwm_cnt   <= r_pwm_cnt + PWM_W'(1);
      end
   end

   assign o_cfg_ready = r_cfg_ready;
   assign w_wr        = i_cfg_valid & r_cfg_ready;

   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
      localparam logic [1:0]        RST_MODE = (g == 0) ? MODE_BLINK : MODE_OFF;
      localparam logic [RATE_W-1:0] RST_RATE = RATE_W'((g == 0) ? RESET_RATE : 0);

      logic              w_sel;
      logic [1:0]        r_mode;
      logic [RATE_W-1:0] r_rate;
      logic [PWM_W-1:0]  r_duty;
      logic [RATE_W-1:0] r_cnt;
      logic              r_state;
      logic              r_led;

      // Out-of-range channel numbers match no channel, so such writes are dropped
      assign w_sel = w_wr && (i_cfg_chan == CHAN_W'(g));

      // A write restarts the channel phase and takes priority over a coincident tick
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_mode  <= RST_MODE;
            r_rate  <= RST_RATE;
            r_duty  <= '0;
            r_cnt   <= '0;
            r_state <= 1'b0;
         end else if (w_sel) begin
            r_mode  <= i_cfg_mode;
            r_rate  <= i_cfg_rate;
            r_duty  <= i_cfg_duty;
            r_cnt   <= '0;
            r_state <= 1'b0;
         end else if (w_tick && (r_mode == MODE_BLINK)) begin
            if (r_cnt == r_rate) begin
               r_cnt   <= '0;
               r_state <= ~r_state;
            end else begin
               r_cnt   <= r_cnt + RATE_W'(1);
            end
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_led <= 1'b0;
         end else begin
            unique case (r_mode)
               MODE_OFF:   r_led <= 1'b0;
               MODE_ON:    r_led <= 1'b1;
               MODE_BLINK: r_led <= r_state;
               MODE_PWM:   r_led <= (r_pwm_cnt < r_duty);
               default:    r_led <= 1'b0;
            endcase
         end
      end

      assign o_led[g] = r_led;
   end

endmodule

// File: tb/tb_led_channel_blinker.sv
// Self-checking bench for led_channel_blinker: an arithmetic reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_led_channel_blinker;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_chan;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_rate;
   logic [7:0] cfg_duty;
   logic [3:0] led;

   // Second instance with 5 channels so that channel numbers 5..7 are out of range
   logic       cfg_valid5;
   logic       cfg_ready5;
   logic [2:0] cfg_chan5;
   logic [4:0] led5;

   always #5 clk = ~clk;

   led_channel_blinker #(
      .NUM_LEDS (4),
      .CLK_HZ   (1000),
      .TICK_HZ  (100),
      .RATE_W   (8),
      .PWM_W    (8)
   ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cfg_valid (cfg_valid),
      .o_cfg_ready (cfg_ready),
      .i_cfg_chan  (cfg_chan),
      .i_cfg_mode  (cfg_mode),
      .i_cfg_rate  (cfg_rate),
      .i_cfg_duty  (cfg_duty),
      .o_led       (led)
   );

   led_channel_blinker #(
      .NUM_LEDS (5),
      .CLK_HZ   (1000),
      .TICK_HZ  (100),
      .RATE_W   (8),
      .PWM_W    (8)
   ) u_dut5 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_cfg_valid (cfg_valid5),
      .o_cfg_ready (cfg_ready5),
      .i_cfg_chan  (cfg_chan5),
      .i_cfg_mode  (cfg_mode),
      .i_cfg_rate  (cfg_rate),
      .i_cfg_duty  (cfg_duty),
      .o_led       (led5)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model. e counts clock edges since the last reset edge; a tick is
   // processed at every edge with e a multiple of 10, so after edge p there have
   // been p/10 ticks. A blinking channel toggles once per (rate+1) ticks counted
   // from its last write; the PWM counter after edge p is p mod 256.
   int         e = 0;
   int         m_mode [4];
   int         m_rate [4];
   int         m_duty [4];
   int         m_base [4];
   logic [3:0] exp_led;
   logic [4:0] exp_led5;
   logic       exp_ready;

   function automatic logic blink_at(input int p, input int base, input int rate);
      return (((p / 10 - base) / (rate + 1)) % 2) == 1;
   endfunction

   function automatic logic led_of(input int ch, input int p);
      case (m_mode[ch])
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return blink_at(p, m_base[ch], m_rate[ch]);
         default: return (p % 256) < m_duty[ch];
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            e = 0;
            for (int c = 0; c < 4; c++) begin
               m_mode[c] = (c == 0) ? 2 : 0;
               m_rate[c] = (c == 0) ? 49 : 0;
               m_duty[c] = 0;
               m_base[c] = 0;
            end
            exp_led   = '0;
            exp_led5  = '0;
            exp_ready = 1'b0;
         end else begin
            e++;
            for (int c = 0; c < 4; c++) exp_led[c] = led_of(c, e - 1);
            exp_led5 = {4'b0000, blink_at(e - 1, 0, 49)};
            if (cfg_valid && exp_ready) begin
               m_mode[cfg_chan] = int'(cfg_mode);
               m_rate[cfg_chan] = int'(cfg_rate);
               m_duty[cfg_chan] = int'(cfg_duty);
               m_base[cfg_chan] = e / 10;
            end
            exp_ready = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("led", led, exp_led);
            check("ready", cfg_ready, exp_ready);
            check("led5", led5, exp_led5);
            check("ready5", cfg_ready5, exp_ready);
         end
      end
   end

   task automatic do_write(input int ch, input int mode, input int rate, input int duty);
      cfg_chan  = 2'(ch);
      cfg_mode  = 2'(mode);
      cfg_rate  = 8'(rate);
      cfg_duty  = 8'(duty);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // Edge index after which led[idx] first changes to lvl; -1 if the bound expires
   task automatic wait_edge(input int idx, input logic lvl, input int bound, output int at);
      logic prev;
      prev = led[idx];
      at   = -1;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (led[idx] === lvl && prev !== lvl) begin
            at = e;
            return;
         end
         prev = led[idx];
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      int a1;
      int a2;
      int w;
      int cnt;
      int duties [3] = '{64, 0, 255};

      rst        = 1'b1;
      cfg_valid  = 1'b0;
      cfg_chan   = '0;
      cfg_mode   = '0;
      cfg_rate   = '0;
      cfg_duty   = '0;
      cfg_valid5 = 1'b0;
      cfg_chan5  = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;

      // Reset release and the default heartbeat
      check("rst_led", led, 0);
      check("rst_ready", cfg_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_release", cfg_ready, 1);
      wait_edge(0, 1'b1, 600, at);
      check("hb_rise_edge", at, 501);
      check("hb_others_off", led[3:1], 0);
      wait_edge(0, 1'b0, 600, at);
      check("hb_fall_edge", at, 1001);

      // rate=0 blink and ON latency
      do_write(1, 2, 0, 0);
      do_write(2, 1, 0, 0);
      check("on_before", led[2], 0);
      @(negedge clk);
      check("on_after", led[2], 1);
      wait_edge(1, 1'b1, 40, a1);
      wait_edge(1, 1'b1, 40, a2);
      check("rate0_period", a2 - a1, 20);

      // PWM duty over a full 256-clk frame
      foreach (duties[i]) begin
         do_write(3, 3, 0, duties[i]);
         @(negedge clk);
         cnt = 0;
         repeat (256) begin
            @(negedge clk);
            cnt += int'(led[3]);
         end
         check("pwm_high_count", cnt, duties[i]);
      end

      // Write on a tick edge: the write wins, next toggle 4 ticks later
      while ((e + 1) % 10 != 0) @(negedge clk);
      do_write(0, 2, 3, 0);
      w = e;
      check("tick_write_edge", w % 10, 0);
      wait_edge(0, 1'b1, 80, at);
      check("tick_write_rise", at - w, 41);

      // Out-of-range channel on the 5-channel instance
      cfg_mode   = 2'd1;
      cfg_rate   = 8'd0;
      cfg_duty   = 8'd0;
      cfg_chan5  = 3'd5;
      cfg_valid5 = 1'b1;
      check("oor_ready", cfg_ready5, 1);
      @(negedge clk);
      cfg_chan5 = 3'd7;
      @(negedge clk);
      cfg_valid5 = 1'b0;
      repeat (2) @(negedge clk);
      check("oor_upper_off", led5[4:1], 0);

      // Reset mid-blink with a write pending
      cfg_chan  = 2'd1;
      cfg_mode  = 2'd1;
      cfg_valid = 1'b1;
      rst       = 1'b1;
      @(negedge clk);
      check("mid_rst_led", led, 0);
      check("mid_rst_ready", cfg_ready, 0);
      rst       = 1'b0;
      cfg_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("lost_write", led[1], 0);
      wait_edge(0, 1'b1, 600, at);
      check("hb_restart_rise", at, 501);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
